// File: rtl/lsu_access_aligner.sv
// Load/store alignment unit: splits byte-addressed LSU accesses into word-aligned, byte-enabled memory beats.
// Define LSU_MISALIGN_TRAP_EN to trap word-crossing accesses instead of splitting them into two beats.
module lsu_access_aligner #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [2:0]          i_req_funct3,
  input  logic                i_req_wren,
  input  logic [DATA_W-1:0]   i_req_wdata,
  output logic                o_rsp_valid,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_rsp_err,
  output logic                o_mem_valid,
  input  logic                i_mem_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wren,
  output logic [DATA_W/8-1:0] o_mem_byte_en,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned MW    = 2 * NB;
  localparam int unsigned DW2   = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_ISSUE1,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr0_q;
  logic [NB-1:0]     be0_q, be1_q;
  logic [DATA_W-1:0] wd0_q, wd1_q;
  logic [DATA_W-1:0] rd0_q, rd1_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              uns_q, wren_q, split_q, err_q, cap0_q;

  logic [OFF_W-1:0]  req_off;
  logic [MW-1:0]     req_lane, req_mask2;
  logic [DATA_W-1:0] req_wmasked;
  logic [DW2-1:0]    req_wdata2;
  logic              req_split, req_illegal;

  logic [DW2-1:0]    ld_sh;
  logic [DATA_W-1:0] ld_keep, ld_data;
  logic              ld_sign;

  // Bit mask covering the low 1/2/4 bytes of a word for a given size code.
  function automatic logic [DATA_W-1:0] size_keep(input logic [1:0] size);
    case (size)
      2'b00:   size_keep = DATA_W'(8'hFF);
      2'b01:   size_keep = DATA_W'(16'hFFFF);
      default: size_keep = DATA_W'(32'hFFFF_FFFF);
    endcase
  endfunction

  // Request decode: lane mask across two words, positioned store data, legality.
  always_comb begin
    req_off = i_req_addr[OFF_W-1:0];
    case (i_req_funct3[1:0])
      2'b00:   req_lane = MW'(1);
      2'b01:   req_lane = MW'(3);
      default: req_lane = MW'(15);
    endcase
    req_mask2   = req_lane << req_off;
    req_wmasked = i_req_wdata & size_keep(i_req_funct3[1:0]);
    req_wdata2  = DW2'(req_wmasked) << {req_off, 3'b000};
    req_split   = |req_mask2[MW-1:NB];
    req_illegal = (i_req_funct3[1:0] == 2'b11) ||
                  ((i_req_funct3[1:0] == 2'b10) && (DATA_W < 32)) ||
                  (i_req_wren && i_req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    req_illegal = req_illegal || req_split;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flags that the word returned this cycle belongs to beat0 of a load.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cap0_q <= 1'b0;
    end else begin
      cap0_q <= (state_q == S_ISSUE0) && i_mem_ready && !wren_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if ((state_q == S_IDLE) && i_req_valid) begin
      addr0_q <= {i_req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      be0_q   <= req_mask2[NB-1:0];
      be1_q   <= req_mask2[MW-1:NB];
      wd0_q   <= req_wdata2[DATA_W-1:0];
      wd1_q   <= req_wdata2[DW2-1:DATA_W];
      off_q   <= req_off;
      size_q  <= i_req_funct3[1:0];
      uns_q   <= i_req_funct3[2];
      wren_q  <= i_req_wren;
      split_q <= req_split;
      err_q   <= req_illegal;
    end
    if (cap0_q) begin
      rd0_q <= i_mem_rdata;
    end
    if ((state_q == S_WAIT) && split_q) begin
      rd1_q <= i_mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_req_valid) state_d = req_illegal ? S_RESP : S_ISSUE0;
      S_ISSUE0: begin
        if (i_mem_ready) begin
          if (split_q)     state_d = S_ISSUE1;
          else if (wren_q) state_d = S_RESP;
          else             state_d = S_WAIT;
        end
      end
      S_ISSUE1: if (i_mem_ready) state_d = wren_q ? S_RESP : S_WAIT;
      S_WAIT:   state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Load merge: shift the two-word window down by the byte offset, then extend.
  always_comb begin
    ld_sh   = {rd1_q, rd0_q} >> {off_q, 3'b000};
    ld_keep = size_keep(size_q);
    case (size_q)
      2'b00:   ld_sign = !uns_q && ld_sh[7];
      2'b01:   ld_sign = !uns_q && ld_sh[15];
      default: ld_sign = !uns_q && ld_sh[31];
    endcase
    ld_data = (ld_sh[DATA_W-1:0] & ld_keep) | (ld_sign ? ~ld_keep : '0);
  end

  always_comb begin
    o_req_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    o_rsp_rdata   = '0;
    o_rsp_err     = 1'b0;
    o_mem_valid   = 1'b0;
    o_mem_addr    = '0;
    o_mem_wren    = 1'b0;
    o_mem_byte_en = '0;
    o_mem_wdata   = '0;
    case (state_q)
      S_IDLE: o_req_ready = 1'b1;
      S_ISSUE0: begin
        o_mem_valid   = 1'b1;
        o_mem_addr    = addr0_q;
        o_mem_wren    = wren_q;
        o_mem_byte_en = wren_q ? be0_q : '1;
        o_mem_wdata   = wren_q ? wd0_q : '0;
      end
      S_ISSUE1: begin
        o_mem_valid   = 1'b1;
        o_mem_addr    = addr0_q + ADDR_W'(NB);
        o_mem_wren    = wren_q;
        o_mem_byte_en = wren_q ? be1_q : '1;
        o_mem_wdata   = wren_q ? wd1_q : '0;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = err_q;
        o_rsp_rdata = (wren_q || err_q) ? '0 : ld_data;
      end
      default: ;
    endcase
  end

endmodule
